if_fetch: RTL and testbench
===========================

Name: if_fetch

Overview:
- Instruction-fetch initiator and the requesting end of the instruction-ROM interface.
- Owns the PC and drives the ROM's ce, addr and isTaken inputs.
- Captures the returned instruction and isTaken flag into the IF/ID pipeline register.
- Handles pipeline stall, flush/redirect and an optional BTB-based taken prediction.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- BTB_LOG2, 4, log2 of BTB entry count; only used with the optional feature.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- stall  in  1  hold PC and IF/ID.
- flush  in  1  redirect fetch to flush_pc and squash IF/ID.
- flush_pc  in  32  redirect target.
- br_update  in  1  resolved-branch update strobe from EX.
- br_pc  in  32  PC of resolved branch.
- br_taken  in  1  actual outcome.
- br_target  in  32  actual target.
- rom_ce  out  1  ROM chip enable.
- rom_addr  out  32  ROM byte address.
- rom_is_taken  out  1  prediction tag sent with the request.
- rom_inst  in  32  instruction returned by the ROM.
- rom_is_taken_ret  in  1  prediction tag returned by the ROM.
- id_pc  out  32  IF/ID PC.
- id_inst  out  32  IF/ID instruction.
- id_is_taken  out  1  IF/ID prediction flag.
- id_valid  out  1  IF/ID slot holds a real instruction.

Behaviour:
- Reset (rst=0, asynchronous):
  - pc=RESET_PC, ce_q=0.
  - id_pc=0, id_inst=0, id_is_taken=0, id_valid=0.
  - All BTB valid bits cleared.
- ROM timing:
  - The ROM is combinational; rom_inst and rom_is_taken_ret are valid in the same cycle as rom_addr.
  - rom_ce=ce_q; rom_addr=pc; rom_is_taken=pred_taken(pc) & ce_q.
- ce_q goes 1 on the first rising edge after rst deasserts and stays 1. That cycle fetches RESET_PC. While ce_q=0, pc holds.
- Priority per edge (ce_q=1): flush > stall > normal.
  - flush: pc <= {flush_pc[31:2],2'b00}; IF/ID <= zeros with id_valid=0. Applies even when stall=1.
  - stall (no flush): pc and all IF/ID outputs hold.
  - normal:
    - id_pc <= pc; id_inst <= rom_inst; id_is_taken <= rom_is_taken_ret; id_valid <= 1.
    - pc <= pred_taken ? pred_target : pc+4.
- ce_q=0 cycle: IF/ID loads zeros, id_valid=0.
- Arithmetic: pc+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0. PC bits[1:0] are always 0.
- Without the optional feature: pred_taken=0 and rom_is_taken=0.
- br_* inputs are ignored when the feature is compiled out.

Optional Feature:
- Macro: IF_FETCH_BTB_EN.
- With the macro defined, a direct-mapped BTB of 2^BTB_LOG2 entries is built. Each entry holds valid, tag (pc[31:BTB_LOG2+2]), 32-bit target and a 2-bit saturating counter.
- Lookup (combinational on pc): hit = valid & tag match. pred_taken = hit & ctr[1]. pred_target = entry target.
- Update (registered, on br_update):
  - Tag match: ctr saturating +1 if br_taken, -1 otherwise; target <= br_target when taken.
  - Tag miss: allocate only if br_taken, with valid=1, new tag, target=br_target, ctr=2'b10. Not-taken misses leave the entry untouched.
- Same-cycle lookup and update of one index: lookup sees the pre-update contents.
- Without the macro: no BTB storage and the always-not-taken behaviour above.

Decomposition:
- Shared defines package:
  - ZeroWord, One/Zero, InstAddrBus, InstBus.
  - BTB_LOG2 default.
  - 2-bit counter encodings (SNT=00, WNT=01, WT=10, ST=11).
- Natural sub-module: if_btb (storage, lookup, update), instantiated only under IF_FETCH_BTB_EN.
- The top holds PC, ce_q, priority logic and the IF/ID register.

Test Plan:
- Reset release with RESET_PC=0 and the ROM returning addr-derived data -> rom_ce=0 until the first edge after reset; id_pc then sequences 0,4,8 with id_valid=1.
- stall=1 for 3 cycles at pc=8 -> rom_addr stays 8 and IF/ID holds pc=4 for all 3 cycles; sequencing resumes at 8 after release.
- flush=1 with stall=1, flush_pc=32'h0000_0103 -> next rom_addr=32'h0000_0100, id_valid=0 that cycle, id_pc=0x100 the following cycle.
- Wrap: flush_pc=32'hFFFF_FFFC with a normal advance -> next rom_addr=0.
- BTB_EN: br_update taken for pc=0x10, target 0x80 -> next fetch of 0x10 drives rom_is_taken=1, id_is_taken=1 and next pc=0x80. Two not-taken updates then return the prediction to 0 (ctr 10->01->00).
- BTB_EN: aliasing pc=0x50 (same index as 0x10, different tag) with a not-taken update -> entry for 0x10 unchanged and still predicts taken.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// Shared constants, bus types and branch-counter encodings for the instruction-fetch slice.
// Imported by if_fetch and, when IF_FETCH_BTB_EN is defined, by if_btb.
package if_fetch_pkg;

    localparam int INST_ADDR_W = 32;
    localparam int INST_W      = 32;

    typedef logic [INST_ADDR_W-1:0] inst_addr_t;
    typedef logic [INST_W-1:0]      inst_t;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
    localparam logic        ONE       = 1'b1;
    localparam logic        ZERO      = 1'b0;

    localparam int BTB_LOG2_DEF = 4;

    // 2-bit saturating direction counter; the MSB is the taken prediction.
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    // IF/ID pipeline register contents.
    typedef struct packed {
        inst_addr_t pc;
        inst_t      inst;
        logic       is_taken;
        logic       valid;
    } ifid_t;

    function automatic ctr_e ctr_update(input ctr_e c, input logic taken);
        ctr_e r;
        r = c;
        if (taken) begin
            if (c != ST) r = ctr_e'(c + 2'd1);
        end else begin
            if (c != SNT) r = ctr_e'(c - 2'd1);
        end
        return r;
    endfunction

endpackage

// File: rtl/if_btb.sv
// Direct-mapped branch target buffer with 2-bit counters, built only when IF_FETCH_BTB_EN is defined.
// Lookup is combinational on the fetch PC; updates from resolved branches land on the clock edge.
module if_btb
    import if_fetch_pkg::*;
#(
    parameter int BTB_LOG2 = BTB_LOG2_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] lookup_pc_i,
    output logic        pred_taken_o,
    output logic [31:0] pred_target_o,
    input  logic        upd_en_i,
    input  logic [31:0] upd_pc_i,
    input  logic        upd_taken_i,
    input  logic [31:0] upd_target_i
);

    localparam int ENTRIES = 1 << BTB_LOG2;
    localparam int TAG_W   = 32 - BTB_LOG2 - 2;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [29:0]        target_q [ENTRIES];
    ctr_e               ctr_q    [ENTRIES];

    logic [BTB_LOG2-1:0] rd_idx;
    logic [BTB_LOG2-1:0] wr_idx;
    logic [TAG_W-1:0]    rd_tag;
    logic [TAG_W-1:0]    wr_tag;
    logic                rd_hit;
    logic                wr_hit;
    logic                wr_alloc;

    assign rd_idx = lookup_pc_i[BTB_LOG2+1:2];
    assign rd_tag = lookup_pc_i[31:BTB_LOG2+2];
    assign wr_idx = upd_pc_i[BTB_LOG2+1:2];
    assign wr_tag = upd_pc_i[31:BTB_LOG2+2];

    // Lookup reads the registered arrays, so a same-edge update is not visible yet.
    assign rd_hit        = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign pred_taken_o  = rd_hit && (ctr_q[rd_idx] inside {WT, ST});
    assign pred_target_o = {target_q[rd_idx], 2'b00};

    assign wr_hit   = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
    assign wr_alloc = upd_en_i && !wr_hit && upd_taken_i;

    // Word-aligned addresses only; the byte-offset bits carry no information here.
    logic unused_low;
    assign unused_low = ^{lookup_pc_i[1:0], upd_pc_i[1:0], upd_target_i[1:0]};

    // NOTE: sequential state is written with <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
        end else if (wr_alloc) begin
            valid_q[wr_idx] <= ONE;
        end
    end

    // NOTE: payload arrays are not reset; valid_q gates every use, which keeps them RAM-mappable.
    always_ff @(posedge clk) begin
        if (upd_en_i) begin
            if (wr_hit) begin
                ctr_q[wr_idx] <= ctr_update(ctr_q[wr_idx], upd_taken_i);
                if (upd_taken_i) begin
                    target_q[wr_idx] <= upd_target_i[31:2];
                end
            end else if (upd_taken_i) begin
                tag_q[wr_idx]    <= wr_tag;
                target_q[wr_idx] <= upd_target_i[31:2];
                ctr_q[wr_idx]    <= WT;
            end
        end
    end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, drives the combinational instruction ROM and loads IF/ID.
// Define IF_FETCH_BTB_EN to add BTB-based taken prediction; otherwise fetch is always-not-taken.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          BTB_LOG2 = BTB_LOG2_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic        br_update,
    input  logic [31:0] br_pc,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        rom_ce,
    output logic [31:0] rom_addr,
    output logic        rom_is_taken,
    input  logic [31:0] rom_inst,
    input  logic        rom_is_taken_ret,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic        id_is_taken,
    output logic        id_valid
);

    inst_addr_t pc_q;
    inst_addr_t pc_d;
    logic       ce_q;
    logic       ce_d;
    ifid_t      ifid_q;
    ifid_t      ifid_d;
    logic       pred_taken;
    inst_addr_t pred_target;

    logic unused_flush_low;
    assign unused_flush_low = ^flush_pc[1:0];

`ifdef IF_FETCH_BTB_EN
    if_btb #(
        .BTB_LOG2(BTB_LOG2)
    ) u_btb (
        .clk           (clk),
        .rst           (rst),
        .lookup_pc_i   (pc_q),
        .pred_taken_o  (pred_taken),
        .pred_target_o (pred_target),
        .upd_en_i      (br_update),
        .upd_pc_i      (br_pc),
        .upd_taken_i   (br_taken),
        .upd_target_i  (br_target)
    );
`else
    assign pred_taken  = ZERO;
    assign pred_target = ZERO_WORD;

    // Branch resolution has no consumer without a BTB.
    logic                unused_br;
    logic [BTB_LOG2-1:0] unused_btb_idx;
    assign unused_br      = ^{br_update, br_pc, br_taken, br_target};
    assign unused_btb_idx = '0;
`endif

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        pc_d   = pc_q;
        ce_d   = ONE;
        ifid_d = ifid_q;
        if (!ce_q) begin
            ifid_d = '0;
        end else if (flush) begin
            pc_d   = {flush_pc[31:2], 2'b00};
            ifid_d = '0;
        end else if (!stall) begin
            ifid_d = '{pc: pc_q, inst: rom_inst, is_taken: rom_is_taken_ret, valid: ONE};
            pc_d   = pred_taken ? pred_target : pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q   <= RESET_PC;
            ce_q   <= ZERO;
            ifid_q <= '0;
        end else begin
            pc_q   <= pc_d;
            ce_q   <= ce_d;
            ifid_q <= ifid_d;
        end
    end

    assign rom_ce       = ce_q;
    assign rom_addr     = pc_q;
    assign rom_is_taken = pred_taken & ce_q;

    assign id_pc       = ifid_q.pc;
    assign id_inst     = ifid_q.inst;
    assign id_is_taken = ifid_q.is_taken;
    assign id_valid    = ifid_q.valid;

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed reset/stall/flush/wrap (and BTB when
// IF_FETCH_BTB_EN is defined), then randomized traffic against a behavioural model.
module tb_if_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          L        = 4;
    localparam int          N        = 1 << L;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = 32'h0;
    logic        br_update = 1'b0;
    logic [31:0] br_pc = 32'h0;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = 32'h0;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic        rom_is_taken;
    logic [31:0] rom_inst;
    logic        rom_is_taken_ret;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_is_taken;
    logic        id_valid;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_fn(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    // Combinational ROM: data derived from the address, prediction tag echoed back.
    assign rom_inst         = rom_fn(rom_addr);
    assign rom_is_taken_ret = rom_is_taken;

    if_fetch #(
        .RESET_PC (RESET_PC),
        .BTB_LOG2 (L)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .flush            (flush),
        .flush_pc         (flush_pc),
        .br_update        (br_update),
        .br_pc            (br_pc),
        .br_taken         (br_taken),
        .br_target        (br_target),
        .rom_ce           (rom_ce),
        .rom_addr         (rom_addr),
        .rom_is_taken     (rom_is_taken),
        .rom_inst         (rom_inst),
        .rom_is_taken_ret (rom_is_taken_ret),
        .id_pc            (id_pc),
        .id_inst          (id_inst),
        .id_is_taken      (id_is_taken),
        .id_valid         (id_valid)
    );

    // Reference model state.
    logic [31:0] m_pc;
    bit          m_ce;
    logic [31:0] m_id_pc;
    logic [31:0] m_id_inst;
    bit          m_id_taken;
    bit          m_id_valid;
`ifdef IF_FETCH_BTB_EN
    bit          b_valid  [N];
    logic [31:0] b_tag    [N];
    logic [31:0] b_target [N];
    int          b_ctr    [N];
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit model_pred(input logic [31:0] pc, output logic [31:0] tgt);
        bit p;
        p   = 1'b0;
        tgt = 32'h0;
`ifdef IF_FETCH_BTB_EN
        begin
            int idx;
            idx = int'((pc >> 2) % N);
            if (b_valid[idx] && b_tag[idx] == (pc >> (L + 2)) && b_ctr[idx] >= 2) begin
                p   = 1'b1;
                tgt = b_target[idx];
            end
        end
`endif
        return p;
    endfunction

`ifdef IF_FETCH_BTB_EN
    task automatic model_btb_update(input logic [31:0] pc, input bit taken, input logic [31:0] tgt);
        int idx;
        idx = int'((pc >> 2) % N);
        if (b_valid[idx] && b_tag[idx] == (pc >> (L + 2))) begin
            if (taken) begin
                b_ctr[idx]    = (b_ctr[idx] < 3) ? b_ctr[idx] + 1 : 3;
                b_target[idx] = tgt & ~32'h3;
            end else begin
                b_ctr[idx] = (b_ctr[idx] > 0) ? b_ctr[idx] - 1 : 0;
            end
        end else if (taken) begin
            b_valid[idx]  = 1'b1;
            b_tag[idx]    = pc >> (L + 2);
            b_target[idx] = tgt & ~32'h3;
            b_ctr[idx]    = 2;
        end
    endtask
`endif

    task automatic model_reset();
        m_pc       = RESET_PC;
        m_ce       = 1'b0;
        m_id_pc    = 32'h0;
        m_id_inst  = 32'h0;
        m_id_taken = 1'b0;
        m_id_valid = 1'b0;
`ifdef IF_FETCH_BTB_EN
        for (int i = 0; i < N; i++) begin
            b_valid[i]  = 1'b0;
            b_tag[i]    = 32'h0;
            b_target[i] = 32'h0;
            b_ctr[i]    = 0;
        end
`endif
    endtask

    task automatic compare_all();
        logic [31:0] t;
        bit          p;
        p = model_pred(m_pc, t);
        check("rom_ce",       32'(rom_ce),       32'(m_ce));
        check("rom_addr",     rom_addr,          m_pc);
        check("rom_is_taken", 32'(rom_is_taken), 32'(p & m_ce));
        check("id_pc",        id_pc,             m_id_pc);
        check("id_inst",      id_inst,           m_id_inst);
        check("id_is_taken",  32'(id_is_taken),  32'(m_id_taken));
        check("id_valid",     32'(id_valid),     32'(m_id_valid));
    endtask

    task automatic drive(input bit s, input bit f, input logic [31:0] fp,
                         input bit bu, input logic [31:0] bp, input bit bt, input logic [31:0] btg);
        stall     = s;
        flush     = f;
        flush_pc  = fp;
        br_update = bu;
        br_pc     = bp;
        br_taken  = bt;
        br_target = btg;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    // Advance the model by one edge from the current inputs, clock the DUT, compare at negedge.
    task automatic do_cycle();
        logic [31:0] t;
        bit          p;
        p = model_pred(m_pc, t);
        if (!m_ce) begin
            m_id_pc = 32'h0; m_id_inst = 32'h0; m_id_taken = 1'b0; m_id_valid = 1'b0;
            m_ce = 1'b1;
        end else if (flush) begin
            m_pc    = flush_pc & ~32'h3;
            m_id_pc = 32'h0; m_id_inst = 32'h0; m_id_taken = 1'b0; m_id_valid = 1'b0;
        end else if (!stall) begin
            m_id_pc    = m_pc;
            m_id_inst  = rom_fn(m_pc);
            m_id_taken = p;
            m_id_valid = 1'b1;
            m_pc       = p ? t : m_pc + 32'd4;
        end
`ifdef IF_FETCH_BTB_EN
        if (br_update) model_btb_update(br_pc, br_taken, br_target);
`endif
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        model_reset();
        idle();
        #1;
        compare_all();
        check("reset_rom_ce", 32'(rom_ce), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        compare_all();
        check("ce_before_first_edge", 32'(rom_ce), 32'h0);

        do_cycle();
        check("first_fetch_addr", rom_addr, RESET_PC);
        check("first_fetch_ce", 32'(rom_ce), 32'h1);
        do_cycle();
        check("seq_id_pc0", id_pc, 32'h0);
        check("seq_valid0", 32'(id_valid), 32'h1);
        do_cycle();
        check("seq_id_pc4", id_pc, 32'h4);
        check("seq_addr8", rom_addr, 32'h8);

        drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            do_cycle();
            check("stall_addr", rom_addr, 32'h8);
            check("stall_id_pc", id_pc, 32'h4);
        end
        idle();
        do_cycle();
        check("resume_id_pc8", id_pc, 32'h8);

        drive(1'b1, 1'b1, 32'h0000_0103, 1'b0, 32'h0, 1'b0, 32'h0);
        do_cycle();
        check("flush_addr", rom_addr, 32'h0000_0100);
        check("flush_squash", 32'(id_valid), 32'h0);
        idle();
        do_cycle();
        check("flush_id_pc", id_pc, 32'h0000_0100);

        drive(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 32'h0);
        do_cycle();
        check("wrap_pre", rom_addr, 32'hFFFF_FFFC);
        idle();
        do_cycle();
        check("wrap_addr", rom_addr, 32'h0);

`ifdef IF_FETCH_BTB_EN
        drive(1'b0, 1'b1, 32'h10, 1'b1, 32'h10, 1'b1, 32'h80);
        do_cycle();
        check("btb_alloc_pred", 32'(rom_is_taken), 32'h1);
        idle();
        do_cycle();
        check("btb_id_taken", 32'(id_is_taken), 32'h1);
        check("btb_redirect", rom_addr, 32'h80);
        drive(1'b0, 1'b1, 32'h10, 1'b1, 32'h50, 1'b0, 32'h0);
        do_cycle();
        check("btb_alias_keep", 32'(rom_is_taken), 32'h1);
        drive(1'b0, 1'b1, 32'h10, 1'b1, 32'h10, 1'b0, 32'h0);
        do_cycle();
        do_cycle();
        check("btb_decay", 32'(rom_is_taken), 32'h0);
`endif

        for (int i = 0; i < 400; i++) begin
            bit          s;
            bit          f;
            bit          bu;
            bit          bt;
            logic [31:0] fp;
            logic [31:0] bp;
            logic [31:0] btg;
            s   = ($urandom_range(0, 3) == 0);
            f   = ($urandom_range(0, 7) == 0);
            fp  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                              : ($urandom & 32'h0000_00FF);
            bu  = ($urandom_range(0, 2) == 0);
            bt  = ($urandom_range(0, 1) == 1);
            bp  = ($urandom_range(0, 1) == 0) ? m_pc : ($urandom & 32'h0000_00FC);
            btg = $urandom & 32'h0000_00FF;
            drive(s, f, fp, bu, bp, bt, btg);
            do_cycle();
        end
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
